// File: rtl/m_table_pkg.sv
// Shared types and defaults for the 1/m reciprocal table builder.
package m_table_pkg;

  localparam int DEFAULT_BUFFER_DEPTH  = 2048;
  localparam int DEFAULT_M_TABLE_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV,
    ST_ROUND,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Clock cycles spent on each entry after entry 0: DIV (w+1), ROUND, WRITE.
  function automatic int entry_cycles(input int w);
    return w + 3;
  endfunction

endpackage

// File: rtl/m_table_recip_div.sv
// Sequential restoring divider computing 2^W / divisor, one quotient bit per
// cycle MSB first; go performs the first step, ready rises W cycles later.
module m_table_recip_div #(
  parameter int AW = 11,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [AW-1:0] divisor,
  output logic [W:0]    quotient,
  output logic [AW:0]   remainder,
  output logic          ready
);

  localparam int CW = $clog2(W + 1);

  logic [W:0]    quo_q, quo_d;
  logic [AW:0]   rem_q, rem_d;
  logic [AW:0]   rem_sh;
  logic [AW-1:0] dsr_q, dsr_d;
  logic [AW-1:0] dsr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_bit;

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dsr_d = dsr_q;
    cnt_d = cnt_q;
    dsr   = go ? divisor : dsr_q;
    // The dividend is always 2^W: its only set bit shifts in on the go step.
    rem_sh = go ? {{AW{1'b0}}, 1'b1} : {rem_q[AW-1:0], 1'b0};
    q_bit  = (rem_sh >= {1'b0, dsr});
    if (go || cnt_q != '0) begin
      rem_d = q_bit ? (rem_sh - {1'b0, dsr}) : rem_sh;
      quo_d = go ? {{W{1'b0}}, q_bit} : {quo_q[W-1:0], q_bit};
      dsr_d = dsr;
      cnt_d = go ? CW'(W) : (cnt_q - 1'b1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign ready     = (cnt_q == '0);

endmodule

// File: rtl/m_table_builder.sv
// Builds the ceil(2^W/m) reciprocal table and streams it to the table RAM.
// Optional self-check output check_err is enabled by M_TABLE_BUILDER_CHECK_EN.
module m_table_builder
  import m_table_pkg::*;
#(
  parameter int BUFFER_DEPTH  = DEFAULT_BUFFER_DEPTH,
  parameter int M_TABLE_WIDTH = DEFAULT_M_TABLE_WIDTH,
  localparam int AW = $clog2(BUFFER_DEPTH),
  localparam int W  = M_TABLE_WIDTH
) (
`ifdef M_TABLE_BUILDER_CHECK_EN
  output logic          check_err,
`endif
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          table_valid,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [W-1:0]  wr_data
);

  localparam logic [AW-1:0] LAST_M = AW'(BUFFER_DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] m_q, m_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [W-1:0]  wr_data_q, wr_data_d;
  logic          table_valid_q, table_valid_d;

  logic          div_go;
  logic [AW-1:0] div_divisor;
  logic [W:0]    div_q;
  logic [AW:0]   div_r;
  logic          div_ready;
  logic [W:0]    e_raw;
  logic [W-1:0]  e_sat;

  m_table_recip_div #(.AW(AW), .W(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .go        (div_go),
    .divisor   (div_divisor),
    .quotient  (div_q),
    .remainder (div_r),
    .ready     (div_ready)
  );

  assign div_divisor = m_q + 1'b1;
  assign e_raw       = div_q + {{W{1'b0}}, (div_r != '0)};
  // Only m=1 reaches 2^W; clamp it to all-ones.
  assign e_sat       = e_raw[W] ? {W{1'b1}} : e_raw[W-1:0];

  always_comb begin
    state_d       = state_q;
    m_d           = m_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    table_valid_d = table_valid_q;
    div_go        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_WRITE;
          m_d           = '0;
          wr_addr_d     = '0;
          wr_data_d     = '0;
          table_valid_d = 1'b0;
        end
      end
      ST_DIV: begin
        if (div_ready) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        wr_addr_d = m_q;
        wr_data_d = e_sat;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        if (wr_ready) begin
          if (m_q == LAST_M) begin
            state_d = ST_DONE;
          end else begin
            // The divider starts on the accepting edge, with divisor m+1.
            m_d     = m_q + 1'b1;
            div_go  = 1'b1;
            state_d = ST_DIV;
          end
        end
      end
      ST_DONE: begin
        table_valid_d = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      m_q           <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      table_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_q           <= m_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      table_valid_q <= table_valid_d;
    end
  end

  assign busy        = (state_q == ST_DIV) || (state_q == ST_ROUND) || (state_q == ST_WRITE);
  assign done        = (state_q == ST_DONE);
  assign wr_valid    = (state_q == ST_WRITE);
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign table_valid = table_valid_q;

`ifdef M_TABLE_BUILDER_CHECK_EN
  localparam logic [AW+W-1:0] TWO_W = (AW+W)'(1) << W;

  logic [W-1:0]    e_m1;
  logic [AW+W-1:0] prod_e, prod_e_m1;
  logic            chk_fail;
  logic            check_err_q, check_err_d;

  // e is the smallest value whose product with m reaches 2^W.
  always_comb begin
    e_m1        = e_sat - 1'b1;
    prod_e      = {{W{1'b0}}, m_q} * {{AW{1'b0}}, e_sat};
    prod_e_m1   = {{W{1'b0}}, m_q} * {{AW{1'b0}}, e_m1};
    chk_fail    = (state_q == ST_ROUND) && (m_q != AW'(1)) &&
                  !((prod_e >= TWO_W) && (prod_e_m1 < TWO_W));
    check_err_d = check_err_q;
    if (state_q == ST_IDLE && start) check_err_d = 1'b0;
    else if (chk_fail)               check_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) check_err_q <= 1'b0;
    else     check_err_q <= check_err_d;
  end

  assign check_err = check_err_q;
`endif

endmodule

// File: tb/tb_m_table_builder.sv
// Scoreboard bench: a default-size builder (2048 x 32) and a small one (16 x 8)
// share one clock; a negedge monitor checks every write against queued values.
module tb_m_table_builder;
  import m_table_pkg::*;

  localparam int BD0 = 2048, W0 = 32, AW0 = 11;
  localparam int BD1 = 16,   W1 = 8,  AW1 = 4;
  localparam int CYC0 = entry_cycles(W0);
  localparam int CYC1 = entry_cycles(W1);

  typedef struct packed {
    int unsigned addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, start0, start1, rdy0, rdy1;
  logic busy0, done0, tv0, v0, busy1, done1, tv1, v1;
  logic [AW0-1:0] a0;
  logic [W0-1:0]  d0;
  logic [AW1-1:0] a1;
  logic [W1-1:0]  d1;
`ifdef M_TABLE_BUILDER_CHECK_EN
  logic cerr0, cerr1;
`endif

  m_table_builder #(.BUFFER_DEPTH(BD0), .M_TABLE_WIDTH(W0)) dut0 (
`ifdef M_TABLE_BUILDER_CHECK_EN
    .check_err(cerr0),
`endif
    .clk(clk), .rst(rst0), .start(start0), .busy(busy0), .done(done0),
    .table_valid(tv0), .wr_valid(v0), .wr_ready(rdy0), .wr_addr(a0), .wr_data(d0)
  );

  m_table_builder #(.BUFFER_DEPTH(BD1), .M_TABLE_WIDTH(W1)) dut1 (
`ifdef M_TABLE_BUILDER_CHECK_EN
    .check_err(cerr1),
`endif
    .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .done(done1),
    .table_valid(tv1), .wr_valid(v1), .wr_ready(rdy1), .wr_addr(a1), .wr_data(d1)
  );

  logic        v_a [2], rdy_a [2], done_a [2], busy_a [2], tv_a [2], cerr_a [2];
  int unsigned addr_a [2];
  logic [31:0] data_a [2];

  assign v_a[0] = v0;       assign v_a[1] = v1;
  assign rdy_a[0] = rdy0;   assign rdy_a[1] = rdy1;
  assign done_a[0] = done0; assign done_a[1] = done1;
  assign busy_a[0] = busy0; assign busy_a[1] = busy1;
  assign tv_a[0] = tv0;     assign tv_a[1] = tv1;
  assign addr_a[0] = 32'(a0); assign addr_a[1] = 32'(a1);
  assign data_a[0] = 32'(d0); assign data_a[1] = 32'(d1);
`ifdef M_TABLE_BUILDER_CHECK_EN
  assign cerr_a[0] = cerr0; assign cerr_a[1] = cerr1;
`else
  assign cerr_a[0] = 1'b0;  assign cerr_a[1] = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  exp_t        sb0[$], sb1[$];
  logic [31:0] cap0 [BD0];
  logic [31:0] cap1 [BD1];
  int          start_edge [2], last_acc_edge [2], n_acc [2];
  bit          timing_en [2], prev_stall [2], prev_done [2], done_seen [2];
  int unsigned held_addr [2];
  logic [31:0] held_data [2];
  bit          stall_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  function automatic logic [31:0] golden(input int m, input int w);
    longint unsigned two_w, e;
    two_w = 64'd1 << w;
    if (m == 0) return 32'd0;
    e = (two_w + longint'(m) - 1) / longint'(m);
    if (e >= two_w) e = two_w - 1;
    return e[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor(input int k);
    exp_t x;
    int   sz;
    if (prev_stall[k]) begin
      check($sformatf("stall_valid%0d", k), 64'(v_a[k]), 64'd1);
      check($sformatf("stall_addr%0d", k), 64'(addr_a[k]), 64'(held_addr[k]));
      check($sformatf("stall_data%0d", k), 64'(data_a[k]), 64'(held_data[k]));
    end
    if (v_a[k] && rdy_a[k]) begin
      sz = (k == 0) ? sb0.size() : sb1.size();
      if (sz == 0) begin
        fail($sformatf("extra_write%0d", k), $sformatf("unexpected write addr %0d", addr_a[k]));
      end else begin
        x = (k == 0) ? sb0.pop_front() : sb1.pop_front();
        check($sformatf("wr_addr%0d", k), 64'(addr_a[k]), 64'(x.addr));
        check($sformatf("wr_data%0d[%0d]", k, x.addr), 64'(data_a[k]), 64'(x.data));
        if (timing_en[k])
          check($sformatf("accept_edge%0d[%0d]", k, x.addr), 64'(edge_cnt + 1 - start_edge[k]),
                64'(1 + int'(x.addr) * ((k == 0) ? CYC0 : CYC1)));
        if (k == 0) cap0[addr_a[0] % BD0] = data_a[0];
        else        cap1[addr_a[1] % BD1] = data_a[1];
      end
      last_acc_edge[k] = edge_cnt + 1;
      n_acc[k]++;
    end
    prev_stall[k] = v_a[k] && !rdy_a[k];
    held_addr[k]  = addr_a[k];
    held_data[k]  = data_a[k];
    if (done_a[k]) begin
      sz = (k == 0) ? sb0.size() : sb1.size();
      check($sformatf("done_single%0d", k), 64'(prev_done[k]), 64'd0);
      check($sformatf("writes_left_at_done%0d", k), 64'(sz), 64'd0);
      check($sformatf("done_after_last%0d", k), 64'(edge_cnt), 64'(last_acc_edge[k]));
      check($sformatf("check_err%0d", k), 64'(cerr_a[k]), 64'd0);
      done_seen[k] = 1'b1;
    end
    prev_done[k] = done_a[k];
  endtask

  always @(negedge clk) begin
    monitor(0);
    monitor(1);
  end

  // Stall pattern for the small instance; the large one always accepts.
  initial begin
    rdy1 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy1 = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic push_build(input int k);
    int bd, w;
    bd = (k == 0) ? BD0 : BD1;
    w  = (k == 0) ? W0 : W1;
    for (int m = 0; m < bd; m++) begin
      if (k == 0) sb0.push_back('{addr: m, data: golden(m, w)});
      else        sb1.push_back('{addr: m, data: golden(m, w)});
    end
    n_acc[k]     = 0;
    done_seen[k] = 1'b0;
  endtask

  task automatic pulse_start(input int k, input bit new_build);
    if (new_build) begin
      push_build(k);
      start_edge[k] = edge_cnt + 1;
    end
    if (k == 0) start0 = 1'b1; else start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_acc(input int k, input int n, input int budget);
    int c = 0;
    while (n_acc[k] < n && c < budget) begin tick(); c++; end
    if (n_acc[k] < n) fail($sformatf("accept_timeout%0d", k), $sformatf("%0d of %0d writes", n_acc[k], n));
  endtask

  task automatic wait_done(input int k, input int budget);
    int c = 0;
    while (!done_seen[k] && c < budget) begin tick(); c++; end
    if (!done_seen[k]) fail($sformatf("done_timeout%0d", k), "done never pulsed");
    check($sformatf("table_valid_after_done%0d", k), 64'(tv_a[k]), 64'd1);
    check($sformatf("busy_after_done%0d", k), 64'(busy_a[k]), 64'd0);
  endtask

  task automatic check_zero(input int k, input string tag);
    check($sformatf("%s_busy%0d", tag, k), 64'(busy_a[k]), 64'd0);
    check($sformatf("%s_done%0d", tag, k), 64'(done_a[k]), 64'd0);
    check($sformatf("%s_table_valid%0d", tag, k), 64'(tv_a[k]), 64'd0);
    check($sformatf("%s_wr_valid%0d", tag, k), 64'(v_a[k]), 64'd0);
    check($sformatf("%s_wr_addr%0d", tag, k), 64'(addr_a[k]), 64'd0);
    check($sformatf("%s_wr_data%0d", tag, k), 64'(data_a[k]), 64'd0);
    check($sformatf("%s_check_err%0d", tag, k), 64'(cerr_a[k]), 64'd0);
  endtask

  initial begin
    int valid_cycles;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0; rdy0 = 1'b1;
    repeat (3) tick();
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst0 = 1'b0; rst1 = 1'b0;
    tick();

    // Abort the large build while m=100 is being divided.
    timing_en[0] = 1'b1;
    pulse_start(0, 1'b1);
    wait_acc(0, 100, 5000);
    check("writes_before_abort", 64'(n_acc[0]), 64'd100);
    repeat (10) tick();
    rst0 = 1'b1;
    #1;
    check_zero(0, "abort");
    sb0.delete();
    repeat (2) tick();
    rst0 = 1'b0;
    valid_cycles = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (v0) valid_cycles++;
    end
    check("wr_valid_after_abort", 64'(valid_cycles), 64'd0);
    check("table_valid_after_abort", 64'(tv0), 64'd0);

    // Full default-size build with wr_ready high.
    pulse_start(0, 1'b1);
    check("busy_after_start0", 64'(busy0), 64'd1);
    wait_done(0, 72000);
    check("writes_total0", 64'(n_acc[0]), 64'd2048);
    check("last_accept_edge0", 64'(last_acc_edge[0] - start_edge[0]), 64'd71646);
    check("entry0_0", 64'(cap0[0]), 64'h0000_0000);
    check("entry0_1", 64'(cap0[1]), 64'hFFFF_FFFF);
    check("entry0_2", 64'(cap0[2]), 64'h8000_0000);
    check("entry0_3", 64'(cap0[3]), 64'h5555_5556);
    check("entry0_2047", 64'(cap0[2047]), 64'h0020_0401);

    // Small build under random stalls.
    timing_en[1] = 1'b0;
    stall_en = 1'b1;
    pulse_start(1, 1'b1);
    wait_done(1, 2000);
    stall_en = 1'b0;
    check("writes_total1", 64'(n_acc[1]), 64'd16);
    check("entry1_0", 64'(cap1[0]), 64'd0);
    check("entry1_1", 64'(cap1[1]), 64'd255);
    check("entry1_2", 64'(cap1[2]), 64'd128);
    check("entry1_3", 64'(cap1[3]), 64'd86);
    check("entry1_4", 64'(cap1[4]), 64'd64);
    check("entry1_15", 64'(cap1[15]), 64'd18);

    // Start pulses while busy at m=5 must be ignored; timing is checked per entry.
    tick();
    timing_en[1] = 1'b1;
    pulse_start(1, 1'b1);
    check("table_valid_cleared_by_start", 64'(tv1), 64'd0);
    wait_acc(1, 5, 200);
    pulse_start(1, 1'b0);
    repeat (3) tick();
    pulse_start(1, 1'b0);
    wait_done(1, 400);
    check("writes_total1_busy_start", 64'(n_acc[1]), 64'd16);
    check("last_accept_edge1", 64'(last_acc_edge[1] - start_edge[1]), 64'd166);

    // A start after done rebuilds and clears table_valid.
    tick();
    pulse_start(1, 1'b1);
    check("table_valid_cleared_on_rebuild", 64'(tv1), 64'd0);
    check("busy_on_rebuild", 64'(busy1), 64'd1);
    wait_done(1, 400);
    check("writes_total1_rebuild", 64'(n_acc[1]), 64'd16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
